tt_checker: RTL and testbench
=============================

TT_CHECKER -- requirements
Module: tt_checker

Interface
REQ-001 Parameter EXPECTED, default 16'h0000: golden truth table; bit i is the expected f for input vector i = {a,b,c,d}.
REQ-002 Parameter ORDERED, default 1: when 1, vectors must arrive in ascending order 0..15.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: begin a new run and clear all results.
REQ-006 Port in_valid, input, 1: the driver presents a sampled vector/response beat.
REQ-007 Port in_ready, output, 1: the checker accepts the beat this cycle.
REQ-008 Port in_vec, input, 4: applied vector {a,b,c,d}, with a as the MSB.
REQ-009 Port in_f, input, 1: the DUT response f observed for in_vec.
REQ-010 Port captured, output, 16: f value captured per vector index.
REQ-011 Port seen, output, 16: set of vector indices already accepted.
REQ-012 Port err_count, output, 5: saturating error count.
REQ-013 Port first_err_idx, output, 4: in_vec of the first erroneous beat.
REQ-014 Port first_err_valid, output, 1: first_err_idx holds a valid value.
REQ-015 Port busy, output, 1: high in state RUN.
REQ-016 Port done, output, 1: high in state DONE.
REQ-017 Port pass, output, 1: done high and err_count equal to 0.

Function
REQ-018 The FSM shall have three states: IDLE, RUN and DONE.
REQ-019 Transitions: IDLE -start-> RUN; RUN -16th distinct index accepted-> DONE; DONE -start-> RUN; RUN -start-> RUN (restart).
REQ-020 On every start: clear captured, seen, err_count, first_err_valid, first_err_idx and the next-index counter, all in the cycle after start is sampled.
REQ-021 in_ready shall be combinational: (state == RUN) & ~start.
REQ-022 A beat with start high shall be dropped.
REQ-023 A beat is accepted when in_valid & in_ready; at most one beat is accepted per cycle, and results are visible on the next cycle.
REQ-024 On acceptance of a new index, set captured[in_vec] to in_f and seen[in_vec] to 1.
REQ-025 A beat is erroneous when any of the following holds: in_f != EXPECTED[in_vec]; seen[in_vec] is already 1 (duplicate); ORDERED=1 and in_vec != the next-index counter.
REQ-026 A duplicate beat shall not overwrite captured and shall not advance seen.
REQ-027 Each erroneous beat shall increment err_count by exactly 1, even if several error conditions hold at once.
REQ-028 err_count shall saturate at 31.
REQ-029 first_err_idx and first_err_valid shall be latched only on the first erroneous beat of a run.
REQ-030 The next-index counter shall increment on every accepted non-duplicate beat and be 4 bits wide; its wrap from 15 to 0 coincides with the transition to DONE.
REQ-031 DONE shall be entered in the cycle after the beat that makes seen equal to 16'hFFFF.
REQ-032 In DONE, all result outputs shall hold until start or reset.
REQ-033 in_valid while not in RUN shall be ignored with no state change.

Reset
REQ-034 Asserting rst_n low shall immediately force: state IDLE; captured, seen, err_count, first_err_idx and next-index counter to 0; first_err_valid, busy, done, pass and in_ready to 0.
REQ-035 Reset during RUN shall abandon the run; after release the block stays in IDLE until start.
REQ-036 Deassertion of rst_n shall be synchronised to clk externally; the block has no internal synchroniser.

Structure
REQ-037 Package tt_chk_pkg shall hold the state enum (IDLE, RUN, DONE), VEC_W = 4, N_VEC = 16 and ERR_W = 5.
REQ-038 The saturating error counter shall be a separate sub-module, tt_chk_sat_cnt (width parameter, inc, clr, count).
REQ-039 All other logic shall reside in tt_checker.

Verification
REQ-040 EXPECTED = 16'hA5C3: start, then send vectors 0..15 in order with in_f = EXPECTED[i] -> captured = 16'hA5C3, seen = 16'hFFFF, done = 1 one cycle after the 16th beat, pass = 1, err_count = 0.
REQ-041 Same run, but in_f at vector 5 inverted -> err_count = 1, first_err_idx = 5, first_err_valid = 1, captured[5] = 1, pass = 0.
REQ-042 ORDERED = 1: send 0, 1, 3, then 2 -> err_count = 2, first_err_idx = 3, seen = 16'h000F, state still RUN.
REQ-043 Send vector 4 twice with different in_f -> second beat counted as error; captured[4] keeps the first value; seen[4] = 1.
REQ-044 Assert rst_n low after 7 beats, then release -> all outputs 0, state IDLE, in_ready = 0; in_valid then ignored until start.
REQ-045 start asserted together with in_valid in RUN -> beat dropped, in_ready = 0 that cycle, results cleared next cycle; 40 erroneous beats -> err_count = 31.

Source files
------------

// File: rtl/tt_chk_pkg.sv
// Shared types and sizes for the truth-table checker.
// The vector index is {a,b,c,d}, with a as the MSB.
package tt_chk_pkg;

  localparam int VEC_W = 4;
  localparam int N_VEC = 16;
  localparam int ERR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [N_VEC-1:0] vec_onehot(input logic [VEC_W-1:0] v);
    logic [N_VEC-1:0] one;
    one = {{(N_VEC-1){1'b0}}, 1'b1};
    return one << v;
  endfunction

endpackage

// File: rtl/tt_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module tt_chk_sat_cnt #(
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [DATA_W-1:0] count
);

  localparam logic [DATA_W-1:0] ONE = 1;

  logic [DATA_W-1:0] r_count;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/tt_checker.sv
// Compares 16 sampled vector/response beats against a golden truth table,
// recording captured values, coverage, and a saturating error count.
module tt_checker
  import tt_chk_pkg::*;
#(
  parameter logic [N_VEC-1:0] EXPECTED = 16'h0000,
  parameter bit               ORDERED  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  input  logic             in_f,
  output logic [N_VEC-1:0] captured,
  output logic [N_VEC-1:0] seen,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [VEC_W-1:0] IDX_ONE = 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_VEC-1:0] r_captured;
  logic [N_VEC-1:0] r_seen;
  logic [VEC_W-1:0] r_next_idx;
  logic [VEC_W-1:0] r_first_err_idx;
  logic             r_first_err_valid;
  logic [ERR_W-1:0] w_err_count;

  logic             w_in_ready;
  logic             w_acc;
  logic             w_dup;
  logic             w_bad_f;
  logic             w_bad_ord;
  logic             w_err;
  logic             w_new;
  logic [N_VEC-1:0] w_seen_nxt;

  always_comb begin
    w_in_ready = (r_state == RUN) & ~start;
    w_acc      = in_valid & w_in_ready;
    w_dup      = r_seen[in_vec];
    w_bad_f    = (in_f != EXPECTED[in_vec]);
    w_bad_ord  = ORDERED && (in_vec != r_next_idx);
    // Several simultaneous faults on one beat still count as a single error.
    w_err      = w_acc & (w_bad_f | w_dup | w_bad_ord);
    w_new      = w_acc & ~w_dup;
    w_seen_nxt = r_seen | vec_onehot(in_vec);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN: begin
        if (start) begin
          w_state_nxt = RUN;
        end else if (w_new && (&w_seen_nxt)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: if (start) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_captured <= '0;
      r_seen     <= '0;
      r_next_idx <= '0;
    end else if (start) begin
      r_captured <= '0;
      r_seen     <= '0;
      r_next_idx <= '0;
    end else if (w_new) begin
      r_captured[in_vec] <= in_f;
      r_seen             <= w_seen_nxt;
      r_next_idx         <= r_next_idx + IDX_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_err_idx   <= '0;
      r_first_err_valid <= 1'b0;
    end else if (start) begin
      r_first_err_idx   <= '0;
      r_first_err_valid <= 1'b0;
    end else if (w_err && !r_first_err_valid) begin
      r_first_err_idx   <= in_vec;
      r_first_err_valid <= 1'b1;
    end
  end

  tt_chk_sat_cnt #(
    .DATA_W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .inc  (w_err),
    .count(w_err_count)
  );

  assign in_ready        = w_in_ready;
  assign captured        = r_captured;
  assign seen            = r_seen;
  assign err_count       = w_err_count;
  assign first_err_idx   = r_first_err_idx;
  assign first_err_valid = r_first_err_valid;
  assign busy            = (r_state == RUN);
  assign done            = (r_state == DONE);
  assign pass            = (r_state == DONE) && (w_err_count == '0);

endmodule

// File: tb/tb_tt_checker.sv
// Bench for tt_checker: a behavioural model pushes expected state per beat,
// and each scenario pops and compares after the DUT clock edge.
module tb_tt_checker;
  import tt_chk_pkg::*;

  localparam logic [15:0] EXP = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_vec = '0;
  logic        in_f = 1'b0;
  logic [15:0] captured;
  logic [15:0] seen;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  logic        first_err_valid;
  logic        busy;
  logic        done;
  logic        pass;

  tt_checker #(.EXPECTED(EXP), .ORDERED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_vec(in_vec), .in_f(in_f),
    .captured(captured), .seen(seen), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_valid(first_err_valid),
    .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cap;
    logic [15:0] seen;
    logic [4:0]  err;
    logic [3:0]  fidx;
    logic        fval;
    logic        done;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_tt = EXP;

  logic [15:0] m_cap, m_seen;
  logic [4:0]  m_err;
  logic [3:0]  m_fidx, m_next;
  logic        m_fval, m_run, m_done;

  task automatic model_clear();
    m_cap = '0; m_seen = '0; m_err = '0; m_fidx = '0; m_fval = 1'b0; m_next = '0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model_clear();
    m_run = 1'b1;
    m_done = 1'b0;
  endtask

  task automatic drive_beat(input logic [3:0] v, input logic f);
    exp_t x;
    logic bad;
    @(negedge clk);
    in_vec = v; in_f = f; in_valid = 1'b1;
    if (m_run) begin
      bad = (f != exp_tt[v]) || m_seen[v] || (v != m_next);
      if (!m_seen[v]) begin
        m_cap[v] = f;
        m_seen[v] = 1'b1;
        m_next = m_next + 4'd1;
        if (m_seen == 16'hFFFF) begin
          m_run = 1'b0;
          m_done = 1'b1;
        end
      end
      if (bad) begin
        if (m_err != 5'd31) m_err = m_err + 5'd1;
        if (!m_fval) begin
          m_fval = 1'b1;
          m_fidx = v;
        end
      end
    end
    x.cap = m_cap; x.seen = m_seen; x.err = m_err;
    x.fidx = m_fidx; x.fval = m_fval; x.done = m_done;
    sb_q.push_back(x);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    m_run = 1'b0; m_done = 1'b0;
    #12;
    n_checks++;
    if ({captured, seen, err_count, first_err_idx, first_err_valid, busy, done, pass, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got cap=%h seen=%h err=%0d fidx=%0d fval=%b busy=%b done=%b pass=%b rdy=%b, required all 0",
               captured, seen, err_count, first_err_idx, first_err_valid, busy, done, pass, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pass_run();
    do_start();
    for (int i = 0; i < 16; i++) begin
      drive_beat(4'(i), exp_tt[i]);
      e = sb_q.pop_front();
      n_checks++;
      if ({captured, seen, err_count, done} !== {e.cap, e.seen, e.err, e.done}) begin
        n_fail++;
        $display("FAIL pass_run_beat%0d: got cap=%h seen=%h err=%0d done=%b, required cap=%h seen=%h err=%0d done=%b",
                 i, captured, seen, err_count, done, e.cap, e.seen, e.err, e.done);
      end
    end
    n_checks++;
    if ({captured, seen, err_count, done, pass, busy} !== {16'hA5C3, 16'hFFFF, 5'd0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL pass_run_final: got cap=%h seen=%h err=%0d done=%b pass=%b busy=%b, required A5C3 FFFF 0 1 1 0",
               captured, seen, err_count, done, pass, busy);
    end
    for (int i = 0; i < 2; i++) begin
      drive_beat(4'd3, 1'b1);
      e = sb_q.pop_front();
      n_checks++;
      if ({captured, seen, err_count, done, in_ready} !== {e.cap, e.seen, e.err, e.done, 1'b0}) begin
        n_fail++;
        $display("FAIL done_hold%0d: got cap=%h seen=%h err=%0d done=%b rdy=%b, required cap=%h seen=%h err=%0d done=%b rdy=0",
                 i, captured, seen, err_count, done, in_ready, e.cap, e.seen, e.err, e.done);
      end
    end
  endtask

  task automatic test_single_err();
    do_start();
    for (int i = 0; i < 16; i++) begin
      drive_beat(4'(i), (i == 5) ? ~exp_tt[i] : exp_tt[i]);
      e = sb_q.pop_front();
      n_checks++;
      if ({captured, err_count, first_err_valid} !== {e.cap, e.err, e.fval}) begin
        n_fail++;
        $display("FAIL single_err_beat%0d: got cap=%h err=%0d fval=%b, required cap=%h err=%0d fval=%b",
                 i, captured, err_count, first_err_valid, e.cap, e.err, e.fval);
      end
    end
    n_checks++;
    if ({err_count, first_err_idx, first_err_valid, captured, done, pass} !== {5'd1, 4'd5, 1'b1, 16'hA5E3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_err_final: got err=%0d fidx=%0d fval=%b cap=%h done=%b pass=%b, required 1 5 1 A5E3 1 0",
               err_count, first_err_idx, first_err_valid, captured, done, pass);
    end
  endtask

  task automatic test_order_err();
    logic [3:0] seq [4];
    seq = '{4'd0, 4'd1, 4'd3, 4'd2};
    do_start();
    for (int i = 0; i < 4; i++) begin
      drive_beat(seq[i], exp_tt[seq[i]]);
      e = sb_q.pop_front();
      n_checks++;
      if ({seen, err_count, first_err_idx} !== {e.seen, e.err, e.fidx}) begin
        n_fail++;
        $display("FAIL order_beat%0d: got seen=%h err=%0d fidx=%0d, required seen=%h err=%0d fidx=%0d",
                 i, seen, err_count, first_err_idx, e.seen, e.err, e.fidx);
      end
    end
    n_checks++;
    if ({err_count, first_err_idx, seen, busy, done} !== {5'd2, 4'd3, 16'h000F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL order_final: got err=%0d fidx=%0d seen=%h busy=%b done=%b, required 2 3 000F 1 0",
               err_count, first_err_idx, seen, busy, done);
    end
  endtask

  task automatic test_duplicate();
    do_start();
    for (int i = 0; i < 6; i++) begin
      drive_beat((i == 5) ? 4'd4 : 4'(i), (i == 5) ? ~exp_tt[4] : exp_tt[i]);
      e = sb_q.pop_front();
      n_checks++;
      if ({captured, seen, err_count} !== {e.cap, e.seen, e.err}) begin
        n_fail++;
        $display("FAIL dup_beat%0d: got cap=%h seen=%h err=%0d, required cap=%h seen=%h err=%0d",
                 i, captured, seen, err_count, e.cap, e.seen, e.err);
      end
    end
    n_checks++;
    if ({err_count, captured[4], seen, first_err_idx} !== {5'd1, 1'b0, 16'h001F, 4'd4}) begin
      n_fail++;
      $display("FAIL dup_final: got err=%0d cap4=%b seen=%h fidx=%0d, required 1 0 001F 4",
               err_count, captured[4], seen, first_err_idx);
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 7; i++) begin
      drive_beat(4'(i), exp_tt[i]);
      void'(sb_q.pop_front());
    end
    n_checks++;
    if (seen !== 16'h007F) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got seen=%h, required 007F", seen);
    end
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    m_run = 1'b0; m_done = 1'b0;
    #1;
    n_checks++;
    if ({captured, seen, err_count, first_err_idx, first_err_valid, busy, done, pass, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got cap=%h seen=%h err=%0d busy=%b rdy=%b, required all 0",
               captured, seen, err_count, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(4'd0, exp_tt[0]);
      e = sb_q.pop_front();
      n_checks++;
      if ({captured, seen, err_count, busy, done, in_ready} !== {e.cap, e.seen, e.err, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_ignore%0d: got cap=%h seen=%h err=%0d busy=%b done=%b rdy=%b, required cap=%h seen=%h err=%0d 0 0 0",
                 i, captured, seen, err_count, busy, done, in_ready, e.cap, e.seen, e.err);
      end
    end
  endtask

  task automatic test_start_drop();
    do_start();
    for (int i = 0; i < 3; i++) begin
      drive_beat(4'(i), (i == 1) ? ~exp_tt[i] : exp_tt[i]);
      void'(sb_q.pop_front());
    end
    n_checks++;
    if ({seen, err_count} !== {16'h0007, 5'd1}) begin
      n_fail++;
      $display("FAIL start_drop_pre: got seen=%h err=%0d, required 0007 1", seen, err_count);
    end
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_vec = 4'd3; in_f = exp_tt[3];
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL start_drop_ready: got in_ready=%b, required 0", in_ready);
    end
    @(posedge clk);
    #1 start = 1'b0; in_valid = 1'b0;
    model_clear();
    m_run = 1'b1; m_done = 1'b0;
    n_checks++;
    if ({captured, seen, err_count, first_err_valid, busy} !== {16'h0, 16'h0, 5'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL start_drop_clear: got cap=%h seen=%h err=%0d fval=%b busy=%b, required 0 0 0 0 1",
               captured, seen, err_count, first_err_valid, busy);
    end
    for (int i = 0; i < 40; i++) begin
      drive_beat(4'd0, ~exp_tt[0]);
      e = sb_q.pop_front();
      n_checks++;
      if ({seen, err_count, first_err_idx} !== {e.seen, e.err, e.fidx}) begin
        n_fail++;
        $display("FAIL sat_beat%0d: got seen=%h err=%0d fidx=%0d, required seen=%h err=%0d fidx=%0d",
                 i, seen, err_count, first_err_idx, e.seen, e.err, e.fidx);
      end
    end
    n_checks++;
    if ({err_count, busy} !== {5'd31, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_final: got err=%0d busy=%b, required 31 1", err_count, busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_pass_run();
    test_single_err();
    test_order_err();
    test_duplicate();
    test_reset_mid();
    test_start_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
